// File: rtl/mac_tree_accum.sv
// Pipelined product adder tree with group accumulator,
// arithmetic-shift requantization, saturation and valid/ready output.
module mac_tree_accum #(
  parameter int NUM_PROD   = 8,
  parameter int PROD_WIDTH = 32,
  parameter int ACC_WIDTH  = 40,
  parameter int FRAC_SHIFT = 8,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic [NUM_PROD*PROD_WIDTH-1:0] prod_flat,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_WIDTH-1:0]           out_data,
  output logic                           out_sat
);

  localparam int D = $clog2(NUM_PROD);

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  localparam acc_t OMAX =
    acc_t'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam acc_t OMIN = ~OMAX;

  // Heap-ordered tree: node n sums children 2n and 2n+1;
  // indices NUM_PROD.. are the sign-extended products.
  acc_t node_q [1:NUM_PROD-1];
  acc_t node_d [1:NUM_PROD-1];
  acc_t all_v  [2:2*NUM_PROD-1];

  logic [D-1:0] vld_q, vld_d;
  logic [D-1:0] lst_q, lst_d;

  acc_t acc_q, acc_d;
  acc_t acc_next;
  acc_t shifted;
  logic first_q, first_d;

  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_sat_q, out_sat_d;

  logic en;
  logic tv;
  logic tl;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  assign tv = vld_q[D-1];
  assign tl = lst_q[D-1];

  always_comb begin
    for (int i = 0; i < NUM_PROD; i++) begin
      all_v[NUM_PROD+i] = {
        {(ACC_WIDTH-PROD_WIDTH){
          prod_flat[i*PROD_WIDTH+PROD_WIDTH-1]}},
        prod_flat[i*PROD_WIDTH +: PROD_WIDTH]
      };
    end
    for (int n = 2; n < NUM_PROD; n++) begin
      all_v[n] = node_q[n];
    end
    for (int n = 1; n < NUM_PROD; n++) begin
      node_d[n] = en ? all_v[2*n] + all_v[2*n+1]
                     : node_q[n];
    end
  end

  always_comb begin
    vld_d = vld_q;
    lst_d = lst_q;
    if (en) begin
      vld_d[0] = in_valid;
      lst_d[0] = in_last;
      for (int k = 1; k < D; k++) begin
        vld_d[k] = vld_q[k-1];
        lst_d[k] = lst_q[k-1];
      end
    end
  end

  always_comb begin
    acc_next    = (first_q ? '0 : acc_q) + node_q[1];
    shifted     = acc_next >>> FRAC_SHIFT;
    acc_d       = acc_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (en && tv) begin
      if (tl) begin
        acc_d       = '0;
        first_d     = 1'b1;
        out_valid_d = 1'b1;
        unique case (1'b1)
          (shifted > OMAX): begin
            out_data_d = OMAX[OUT_WIDTH-1:0];
            out_sat_d  = 1'b1;
          end
          (shifted < OMIN): begin
            out_data_d = OMIN[OUT_WIDTH-1:0];
            out_sat_d  = 1'b1;
          end
          default: begin
            out_data_d = shifted[OUT_WIDTH-1:0];
            out_sat_d  = 1'b0;
          end
        endcase
      end else begin
        acc_d   = acc_next;
        first_d = 1'b0;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int n = 1; n < NUM_PROD; n++) begin
        node_q[n] <= '0;
      end
      vld_q       <= '0;
      lst_q       <= '0;
      acc_q       <= '0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      for (int n = 1; n < NUM_PROD; n++) begin
        node_q[n] <= node_d[n];
      end
      vld_q       <= vld_d;
      lst_q       <= lst_d;
      acc_q       <= acc_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_mac_tree_accum.sv
// Directed bench for mac_tree_accum with a group-sum
// reference model and per-cycle output comparison.
module tb_mac_tree_accum;

  localparam int NP = 8;
  localparam int PW = 32;
  localparam int AW = 40;
  localparam int FS = 8;
  localparam int OW = 16;
  localparam int D  = 3;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [NP*PW-1:0] prod_flat;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_sat;

  int errors = 0;
  int checks = 0;
  int n_res  = 0;

  logic [OW:0] exp_q [$];
  int          got_q [$];
  longint      m_acc   = 0;
  bit          m_first = 1'b1;
  longint      m_s;
  logic [OW:0] m_e;
  bit          hold = 1'b0;
  logic [OW-1:0] hold_data;
  logic        hold_sat;

  int          lat;
  logic [OW-1:0] lat_data;
  logic        lat_sat;

  mac_tree_accum dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .prod_flat (prod_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name,
                     input longint got,
                     input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, got, exp);
    end
  endtask

  function automatic longint wrap(input longint x);
    logic [63:0] t;
    t = x;
    return $signed({{(64-AW){t[AW-1]}}, t[AW-1:0]});
  endfunction

  function automatic logic [OW:0] requant(input longint a);
    longint s;
    longint lim;
    s   = a >>> FS;
    lim = longint'(1) <<< (OW - 1);
    if (s > lim - 1) return {1'b1, 1'b0, {(OW-1){1'b1}}};
    if (s < -lim)    return {1'b1, 1'b1, {(OW-1){1'b0}}};
    return {1'b0, s[OW-1:0]};
  endfunction

  function automatic logic [NP*PW-1:0] rep(input int v);
    logic [NP*PW-1:0] r;
    for (int i = 0; i < NP; i++) r[i*PW +: PW] = v;
    return r;
  endfunction

  // Reference model and output comparison.
  always @(negedge ap_clk) begin
    if (out_valid === 1'b1 && out_ready) begin
      n_res++;
      got_q.push_back(int'($signed(out_data)));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0d expected none",
                 $signed(out_data));
      end else begin
        m_e = exp_q.pop_front();
        chk("out_data", $signed(out_data), $signed(m_e[OW-1:0]));
        chk("out_sat", out_sat, m_e[OW]);
      end
    end
    if (hold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, hold_data);
      chk("hold_sat", out_sat, hold_sat);
    end
    hold      = out_valid && !out_ready && !ap_rst;
    hold_data = out_data;
    hold_sat  = out_sat;
    if (ap_rst) begin
      m_acc   = 0;
      m_first = 1'b1;
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      m_s = 0;
      for (int i = 0; i < NP; i++)
        m_s += longint'($signed(prod_flat[i*PW +: PW]));
      m_acc = wrap((m_first ? 0 : m_acc) + m_s);
      if (in_last) begin
        exp_q.push_back(requant(m_acc));
        m_acc   = 0;
        m_first = 1'b1;
      end else begin
        m_first = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input logic [NP*PW-1:0] p,
                       input logic last);
    bit ok;
    int tries;
    ok    = 1'b0;
    tries = 0;
    in_valid  = 1'b1;
    prod_flat = p;
    in_last   = last;
    while (!ok && tries < 100) begin
      @(negedge ap_clk);
      ok = in_ready;
      tick();
      tries++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: got in_ready=0 expected 1");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 50) begin
      @(negedge ap_clk);
      lat++;
      if (out_valid) begin
        seen     = 1'b1;
        lat_data = out_data;
        lat_sat  = out_sat;
      end
      tick();
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_valid_timeout: got none expected result");
    end
  endtask

  initial begin
    logic [NP*PW-1:0] p;
    int n0;
    bit stall;
    bit any;

    ap_rst    = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    prod_flat = '0;
    out_ready = 1'b1;
    idle(3);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();

    drive(rep(256), 1'b1);
    wait_valid();
    chk("t1_latency", lat, D + 1);
    chk("t1_data", $signed(lat_data), 8);
    chk("t1_sat", lat_sat, 0);

    n0 = n_res;
    for (int b = 0; b < 4; b++) drive(rep(1024), b == 3);
    wait_valid();
    chk("t2_latency", lat, D + 1);
    chk("t2_data", $signed(lat_data), 128);
    idle(6);
    chk("t2_count", n_res - n0, 1);

    drive(rep(32'h0100_0000), 1'b1);
    wait_valid();
    chk("t3_pos_data", $signed(lat_data), 32767);
    chk("t3_pos_sat", lat_sat, 1);
    drive(rep(32'hFF00_0000), 1'b1);
    wait_valid();
    chk("t3_neg_data", $signed(lat_data), -32768);
    chk("t3_neg_sat", lat_sat, 1);
    p = '0;
    p[PW-1:0] = 32'hFFFF_FFFF;
    drive(p, 1'b1);
    wait_valid();
    chk("t3_m1_data", $signed(lat_data), -1);
    chk("t3_m1_sat", lat_sat, 0);
    idle(4);

    got_q.delete();
    n0    = n_res;
    stall = 1'b0;
    fork
      begin
        for (int v = 1; v <= 10; v++) drive(rep(v * 32), 1'b1);
      end
      begin
        idle(4);
        out_ready = 1'b0;
        repeat (6) begin
          @(negedge ap_clk);
          if (!in_ready) stall = 1'b1;
          tick();
        end
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 50 && n_res - n0 < 10; i++) tick();
    chk("t4_count", n_res - n0, 10);
    chk("t4_stall_seen", stall, 1);
    for (int i = 0; i < 10; i++)
      chk($sformatf("t4_order%0d", i),
          i < got_q.size() ? got_q[i] : -999, i + 1);

    n0 = n_res;
    for (int g = 0; g < 6; g++) begin
      for (int b = 0; b < 2; b++) begin
        idle($urandom_range(0, 2));
        for (int i = 0; i < NP; i++)
          p[i*PW +: PW] = int'($urandom_range(0, 200000)) - 100000;
        drive(p, b == 1);
      end
    end
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    idle(2);
    chk("t5_drain", exp_q.size(), 0);
    chk("t5_count", n_res - n0, 6);

    drive(rep(100), 1'b0);
    drive(rep(100), 1'b0);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_ready", in_ready, 1);
    tick();
    any = 1'b0;
    repeat (6) begin
      @(negedge ap_clk);
      if (out_valid) any = 1'b1;
      tick();
    end
    chk("t6_no_output", any, 0);
    drive(rep(256), 1'b1);
    wait_valid();
    chk("t6_latency", lat, D + 1);
    chk("t6_data", $signed(lat_data), 8);
    chk("t6_sat", lat_sat, 0);
    idle(4);
    chk("final_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_tree_accum.md
Name: mac_tree_accum

Overview:
- Downstream consumer of the 16x16 signed DSP multiplier bank in the layer-2 MAC tree.
- Each cycle it takes NUM_PROD signed 32-bit products and sums them in a pipelined adder tree.
- It accumulates that sum across a kernel/input-channel group terminated by in_last, requantizes by an arithmetic right shift with saturation, and presents one OUT_WIDTH result per group on a valid/ready output.

Parameters:
- NUM_PROD, 8, number of products per beat; power of two, at least 2. Tree depth D = log2(NUM_PROD).
- PROD_WIDTH, 32, width of each signed product.
- ACC_WIDTH, 40, width of the signed accumulator and adder-tree datapath.
- FRAC_SHIFT, 8, arithmetic right shift applied before saturation.
- OUT_WIDTH, 16, width of the signed output.

Ports:
- ap_clk  in  1  sole clock, rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- in_valid  in  1  product beat present.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_last  in  1  beat is the final beat of its accumulation group.
- prod_flat  in  NUM_PROD*PROD_WIDTH  packed signed products; product i occupies bits [i*PROD_WIDTH +: PROD_WIDTH].
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OUT_WIDTH  saturated, requantized group sum.
- out_sat  out  1  out_data was clamped; qualified by out_valid.

Behaviour:
- Clock/reset: single clock ap_clk; ap_rst is synchronous and active-high.
- Reset clears all tree valid bits, the accumulator, out_valid, out_data and out_sat to 0, and sets the first-beat flag to 1.
- Reset mid-group discards the partial sum and any in-flight beats; no output is produced for that group.
- Global enable: en = !out_valid || out_ready. in_ready = en, combinational. in_ready is 1 in the cycle after reset.
- When en = 0, every pipeline register holds, including valid bits, last bits and the accumulator. No beat is lost or duplicated.
- Input stage: each product is sign-extended to ACC_WIDTH.
- Tree: D registered adder levels; level k adds pairs from level k-1. A valid/last bit travels alongside each level.
- Accumulate stage, on a valid tree output while en = 1:
  - acc_next = (first ? 0 : acc) + tree_sum, wrapping modulo 2^ACC_WIDTH. There is no accumulator saturation.
  - If last = 0: acc <= acc_next, first <= 0.
  - If last = 1:
    - s = acc_next >>> FRAC_SHIFT (arithmetic, floor toward minus infinity).
    - out_data <= clamp(s, -2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1).
    - out_sat <= (s was out of range).
    - out_valid <= 1, first <= 1, acc <= 0.
- Output: out_valid clears on out_valid && out_ready unless a new result loads in the same cycle. Simultaneous consume and load is legal and yields back-to-back results.
- Output stability: out_data and out_sat hold stable while out_valid && !out_ready.
- Latency: a last beat accepted at cycle t gives out_valid at t+D+1 (t+4 at defaults) when there are no stalls. Each stall cycle adds one cycle.
- Throughput: one beat per cycle. Single-beat groups (in_last on every beat) give one result per cycle.
- Bubbles: in_valid = 0 cycles insert bubbles that do not affect the accumulator. Groups may span any number of beats and any gaps.

Test Plan:
- Single-beat group: reset, then one beat with all 8 products = 256 and in_last = 1 -> 4 cycles later out_valid = 1, out_data = 8, out_sat = 0.
- Multi-beat group: 4 beats with products all 1024, the last beat flagged -> sum 32768, out_data = 128, exactly one result, 4 cycles after the last beat.
- Saturation: one last-beat with all products = 0x0100_0000 -> out_data = 32767, out_sat = 1. All products = 0xFF00_0000 -> out_data = -32768, out_sat = 1. Product sum = -1 -> out_data = -1 (floor), out_sat = 0.
- Backpressure: stream 10 single-beat groups with values 1..10 (scaled by 256/8) while out_ready is held low from cycle 5 for 6 cycles -> in_ready drops, out_data holds, all 10 results 1..10 appear in order, none lost or duplicated.
- Back-to-back with gaps: groups of 2 beats with random in_valid bubbles and out_ready = 1 -> results match a reference-model sum per group; the first beat of each group does not include the previous group's sum.
- Reset mid-operation: assert ap_rst after 2 of 3 beats of a group -> out_valid = 0 next cycle. A following fresh 1-beat group of value 8 (products 256) yields out_data = 8 with no residue.
